mcu_component_sched: RTL and testbench

//  Sequences the decoded-sample stream of one JPEG frame into per-component streams for the chroma subsamplers.

---
 rtl/mcu_component_sched.sv | 129 ++++++++++++
 tb/tb_mcu_component_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mcu_component_sched.sv
// mcu_component_sched: splits one frame's IDCT sample stream into Y/Cb/Cr block streams with block/pixel tags.
// Define MCU_SCHED_ERR_EN to build the sticky protocol-error flag on o_err (tied 0 otherwise).
module mcu_component_sched #(
    parameter int Y_BLK_H         = 2,
    parameter int Y_BLK_V         = 2,
    parameter int MCU_WIDTH       = 8,
    parameter int MCU_HEIGHT      = 8,
    parameter int COLOR_PRECISION = 8,
    parameter int MCU_CNT_W       = 16
) (
    input  logic                           i_sysclk,
    input  logic                           i_arst,
    input  logic                           i_sof,
    input  logic [MCU_CNT_W-1:0]           i_mcu_total,
    input  logic                           i_we,
    input  logic [COLOR_PRECISION-1:0]     i_color,
    output logic                           o_ready,
    input  logic                           i_ready,
    output logic                           o_y_we,
    output logic                           o_cb_we,
    output logic                           o_cr_we,
    output logic [COLOR_PRECISION-1:0]     o_color,
    output logic [1:0]                     o_blk_idx,
    output logic [$clog2(MCU_WIDTH)-1:0]   o_pix_x,
    output logic [$clog2(MCU_HEIGHT)-1:0]  o_pix_y,
    output logic                           o_mcu_done,
    output logic                           o_frame_done,
    output logic                           o_err
);
    localparam int PXW = $clog2(MCU_WIDTH);
    localparam int PYW = $clog2(MCU_HEIGHT);
    localparam logic [1:0] BLK_LAST = 2'(Y_BLK_H * Y_BLK_V - 1);

    typedef enum logic [1:0] {S_Y, S_CB, S_CR, S_DONE} state_t;

    state_t               state;
    logic [PXW-1:0]       pix_x;
    logic [PYW-1:0]       pix_y;
    logic [1:0]           blk;
    logic [MCU_CNT_W-1:0] mcu_cnt;
    logic [MCU_CNT_W-1:0] mcu_total;
    logic                 accept;
    logic                 x_last;
    logic                 y_last;
    logic                 blk_end;
    logic                 frame_last;

    assign o_ready    = i_ready && state != S_DONE;
    assign accept     = i_we && o_ready;
    assign x_last     = pix_x == PXW'(MCU_WIDTH - 1);
    assign y_last     = pix_y == PYW'(MCU_HEIGHT - 1);
    assign blk_end    = x_last && y_last;
    assign frame_last = mcu_cnt == mcu_total - MCU_CNT_W'(1);

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            state        <= S_DONE;
            pix_x        <= '0;
            pix_y        <= '0;
            blk          <= '0;
            mcu_cnt      <= '0;
            mcu_total    <= '0;
            o_y_we       <= 1'b0;
            o_cb_we      <= 1'b0;
            o_cr_we      <= 1'b0;
            o_color      <= '0;
            o_blk_idx    <= '0;
            o_pix_x      <= '0;
            o_pix_y      <= '0;
            o_mcu_done   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_y_we       <= 1'b0;
            o_cb_we      <= 1'b0;
            o_cr_we      <= 1'b0;
            o_mcu_done   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_sof) begin
                // an empty frame goes straight to S_DONE so no sample is ever accepted
                state     <= (i_mcu_total == '0) ? S_DONE : S_Y;
                pix_x     <= '0;
                pix_y     <= '0;
                blk       <= '0;
                mcu_cnt   <= '0;
                mcu_total <= i_mcu_total;
            end else if (accept) begin
                o_y_we    <= state == S_Y;
                o_cb_we   <= state == S_CB;
                o_cr_we   <= state == S_CR;
                o_color   <= i_color;
                o_blk_idx <= blk;
                o_pix_x   <= pix_x;
                o_pix_y   <= pix_y;
                pix_x     <= x_last ? '0 : pix_x + PXW'(1);
                if (x_last)
                    pix_y <= y_last ? '0 : pix_y + PYW'(1);
                if (blk_end) begin
                    if (state == S_Y) begin
                        blk   <= (blk == BLK_LAST) ? 2'd0 : blk + 2'd1;
                        state <= (blk == BLK_LAST) ? S_CB : S_Y;
                    end else if (state == S_CB) begin
                        state <= S_CR;
                    end else begin
                        mcu_cnt      <= mcu_cnt + MCU_CNT_W'(1);
                        o_mcu_done   <= 1'b1;
                        o_frame_done <= frame_last;
                        state        <= frame_last ? S_DONE : S_Y;
                    end
                end
            end
        end
    end

`ifdef MCU_SCHED_ERR_EN
    logic mid_mcu;

    assign mid_mcu = state != S_DONE && (state != S_Y || pix_x != '0 || pix_y != '0 || blk != '0);

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst)
            o_err <= 1'b0;
        else if ((i_we && state == S_DONE) || (i_sof && mid_mcu))
            o_err <= 1'b1;
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_component_sched.sv
// tb_mcu_component_sched: random and directed stimulus on a 2x2 and a 1x1 scheduler, checked against a sample-index model.
module tb_mcu_component_sched;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        sof = 1'b0;
    logic        we = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] tot = '0;
    logic [7:0]  color = '0;

    logic       ready [2];
    logic       y_we [2];
    logic       cb_we [2];
    logic       cr_we [2];
    logic       md [2];
    logic       fd [2];
    logic       err [2];
    logic [7:0] ocol [2];
    logic [1:0] oblk [2];
    logic [2:0] ox [2];
    logic [2:0] oy [2];

    always #5 clk = ~clk;

    mcu_component_sched dut0 (
        .i_sysclk(clk), .i_arst(arst), .i_sof(sof), .i_mcu_total(tot), .i_we(we), .i_color(color),
        .o_ready(ready[0]), .i_ready(rdy), .o_y_we(y_we[0]), .o_cb_we(cb_we[0]), .o_cr_we(cr_we[0]),
        .o_color(ocol[0]), .o_blk_idx(oblk[0]), .o_pix_x(ox[0]), .o_pix_y(oy[0]),
        .o_mcu_done(md[0]), .o_frame_done(fd[0]), .o_err(err[0])
    );

    mcu_component_sched #(.Y_BLK_H(1), .Y_BLK_V(1)) dut1 (
        .i_sysclk(clk), .i_arst(arst), .i_sof(sof), .i_mcu_total(tot), .i_we(we), .i_color(color),
        .o_ready(ready[1]), .i_ready(rdy), .o_y_we(y_we[1]), .o_cb_we(cb_we[1]), .o_cr_we(cr_we[1]),
        .o_color(ocol[1]), .o_blk_idx(oblk[1]), .o_pix_x(ox[1]), .o_pix_y(oy[1]),
        .o_mcu_done(md[1]), .o_frame_done(fd[1]), .o_err(err[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a frame is a flat sample index; each MCU is nb luma blocks then Cb then Cr, 64 samples each.
    int         nb [2] = '{4, 1};
    bit         act [2];
    int         cnt [2];
    int         total [2];
    logic [4:0] e_str [2];
    logic [7:0] e_col [2];
    logic [1:0] e_blk [2];
    logic [2:0] e_x [2];
    logic [2:0] e_y [2];
    logic       e_err [2];
    int         n_y [2], n_cb [2], n_cr [2], n_md [2], n_fd [2];

    function automatic logic [31:0] obs_vec(input int d);
        return 32'({y_we[d], cb_we[d], cr_we[d], ocol[d], oblk[d], ox[d], oy[d], md[d], fd[d], err[d]});
    endfunction

    function automatic logic [31:0] exp_vec(input int d);
        return 32'({e_str[d][4:2], e_col[d], e_blk[d], e_x[d], e_y[d], e_str[d][1:0], e_err[d]});
    endfunction

    task automatic model(input int d);
        int spm, r, b, w;
        spm = (nb[d] + 2) * 64;
        e_str[d] = '0;
`ifdef MCU_SCHED_ERR_EN
        if (we && !act[d]) e_err[d] = 1'b1;
        if (sof && act[d] && cnt[d] % spm != 0) e_err[d] = 1'b1;
`endif
        if (sof) begin
            act[d] = tot != 0;
            cnt[d] = 0;
            total[d] = int'(tot);
        end else if (we && rdy && act[d]) begin
            r = cnt[d] % spm;
            b = r / 64;
            w = r % 64;
            e_str[d][4] = b < nb[d];
            e_str[d][3] = b == nb[d];
            e_str[d][2] = b == nb[d] + 1;
            e_str[d][1] = r == spm - 1;
            e_str[d][0] = r == spm - 1 && cnt[d] / spm == total[d] - 1;
            e_col[d] = color;
            e_blk[d] = b < nb[d] ? 2'(b) : 2'd0;
            e_x[d] = 3'(w % 8);
            e_y[d] = 3'(w / 8);
            cnt[d]++;
            if (e_str[d][0]) act[d] = 1'b0;
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0; cnt[d] = 0; total[d] = 0; e_str[d] = '0; e_col[d] = '0;
            e_blk[d] = '0; e_x[d] = '0; e_y[d] = '0; e_err[d] = 1'b0;
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            n_y[d] = 0; n_cb[d] = 0; n_cr[d] = 0; n_md[d] = 0; n_fd[d] = 0;
        end
    endtask

    task automatic step(input logic s, input logic w, input logic r, input logic [15:0] t);
        sof = s; we = w; rdy = r; tot = t; color = 8'($urandom);
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("ready%0d", d), 32'(ready[d]), 32'(r && act[d]));
        @(posedge clk);
        for (int d = 0; d < 2; d++) model(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("out%0d", d), obs_vec(d), exp_vec(d));
            n_y[d] += int'(y_we[d]); n_cb[d] += int'(cb_we[d]); n_cr[d] += int'(cr_we[d]);
            n_md[d] += int'(md[d]); n_fd[d] += int'(fd[d]);
        end
    endtask

    task automatic do_reset();
        sof = 1'b0; we = 1'b0; rdy = 1'b1;
        #2 arst = 1'b1;
        #1 clear_model();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_out%0d", d), obs_vec(d), 32'd0);
            check($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd0);
        end
        @(posedge clk);
        #1 arst = 1'b0;
    endtask

    initial begin
        clear_model();
        clear_stats();
        rdy = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("init_out%0d", d), obs_vec(d), 32'd0);
            check($sformatf("init_ready%0d", d), 32'(ready[d]), 32'd0);
        end
        arst = 1'b0;
        @(posedge clk);
        #1;

        step(1, 0, 1, 16'd1);
        for (int i = 0; i < 384; i++) step(0, 1, 1, 0);
        check("t1_y", n_y[0], 256);
        check("t1_cb", n_cb[0], 64);
        check("t1_cr", n_cr[0], 64);
        check("t1_md_fd", {md[0], fd[0]}, 2'b11);
        check("t1_ndone", n_md[0], 1);

        clear_stats();
        step(1, 0, 1, 16'd3);
        for (int i = 0; i < 576; i++) step(0, 1, 1, 0);
        check("t2_md", n_md[1], 3);
        check("t2_fd", n_fd[1], 1);
        step(0, 0, 1, 0);
        check("t2_ready", ready[1], 1'b0);

        clear_stats();
        step(1, 0, 1, 16'd2);
        for (int i = 0; i < 128; i++) step(0, 1, i % 2 == 0, 0);
        check("t3_y", n_y[0], 64);
        check("t3_x", ox[0], 3'd7);

        step(1, 0, 1, 16'd1);
        for (int i = 0; i < 71; i++) step(0, 1, 1, 0);
        check("t4_tag", {oblk[0], ox[0], oy[0]}, {2'd1, 3'd6, 3'd0});

        step(1, 0, 1, 16'd1);
        for (int i = 0; i < 100; i++) step(0, 1, 1, 0);
        step(1, 0, 1, 16'd1);
        step(0, 1, 1, 0);
        check("t5_tag", {y_we[0], oblk[0], ox[0], oy[0]}, {1'b1, 2'd0, 3'd0, 3'd0});
`ifdef MCU_SCHED_ERR_EN
        check("t5_err", err[0], 1'b1);
`else
        check("t5_err", err[0], 1'b0);
`endif

        step(1, 0, 1, 16'd1);
        for (int i = 0; i < 266; i++) step(0, 1, 1, 0);
        check("t6_pre_cb", cb_we[0], 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0);

        step(1, 0, 1, 16'd2);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(199) == 0, $urandom_range(3) != 0, $urandom_range(3) != 0, 16'($urandom_range(3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
